eth_rx_addr_filter: RTL and testbench

Parametrised receive-side destination-MAC filter between the RGMII MAC RX AXI-Stream output and the iDMA RX stream input. It buffers the 6-byte destination address and matches it against `NumMacEntries` programmable unicast entries plus broadcast, group and promiscuous modes. It then forwards or silently discards the whole frame. Unlike the previous fixed delay-line filter, it honours downstream `tready` backpressure and keeps saturating accept, drop and runt counters.

---
 rtl/eth_rx_addr_filter.sv | 230 +++++++++++++++++++++++
 tb/tb_eth_rx_addr_filter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_addr_filter.sv
// eth_rx_addr_filter
// Receive-side destination MAC filter. It holds the first six bytes of each
// frame, decides in the cycle the sixth byte arrives, and then replays the
// header and passes the rest of the frame, or silently discards it.
// Downstream backpressure is honoured through a single output register.
// Saturating accept/drop/runt counters are also kept.
module eth_rx_addr_filter #(
   parameter int NumMacEntries = 4,
   parameter int CntWidth      = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,

   input  logic [7:0]                 s_axis_tdata_i,
   input  logic                       s_axis_tvalid_i,
   input  logic                       s_axis_tlast_i,
   input  logic                       s_axis_tuser_i,
   output logic                       s_axis_tready_o,

   output logic [7:0]                 m_axis_tdata_o,
   output logic                       m_axis_tvalid_o,
   output logic                       m_axis_tlast_o,
   output logic                       m_axis_tuser_o,
   input  logic                       m_axis_tready_i,

   input  logic [48*NumMacEntries-1:0] cfg_mac_addr_i,
   input  logic [NumMacEntries-1:0]   cfg_mac_en_i,
   input  logic                       cfg_promiscuous_i,
   input  logic                       cfg_accept_bcast_i,
   input  logic                       cfg_accept_group_i,

   input  logic                       cnt_clear_i,
   output logic [CntWidth-1:0]        accept_cnt_o,
   output logic [CntWidth-1:0]        drop_cnt_o,
   output logic [CntWidth-1:0]        runt_cnt_o
);

   typedef enum logic [1:0] {
      ST_HDR,
      ST_REPLAY,
      ST_PASS,
      ST_DROP
   } state_t;

   state_t              r_state;
   logic [2:0]          r_hdrIdx;
   logic [2:0]          r_rdIdx;
   logic [7:0]          r_hdrBuf [0:5];
   logic                r_hdrLast;
   logic                r_hdrUser;
   logic                r_eof;

   logic [7:0]          r_mData;
   logic                r_mValid;
   logic                r_mLast;
   logic                r_mUser;

   logic [CntWidth-1:0] r_acceptCnt;
   logic [CntWidth-1:0] r_dropCnt;
   logic [CntWidth-1:0] r_runtCnt;

   logic                w_outRdy;
   logic                w_sReady;
   logic                w_inHs;
   logic [47:0]         w_dest;
   logic                w_uniHit;
   logic                w_accept;
   logic                w_decide;
   logic                w_acceptInc;
   logic                w_dropInc;
   logic                w_runtInc;

   assign w_outRdy = !r_mValid || m_axis_tready_i;
   assign w_inHs   = s_axis_tvalid_i && w_sReady;

   // The incoming byte completes the address, so the decision needs no extra cycle.
   assign w_dest = {r_hdrBuf[0], r_hdrBuf[1], r_hdrBuf[2], r_hdrBuf[3], r_hdrBuf[4],
                    s_axis_tdata_i};

   // Input ready: the header and drop phases always sink, replay stalls the MAC,
   // and pass-through only sinks when the output register can take the beat.
   always_comb begin
      w_sReady = 1'b1;
      case (r_state)
         ST_HDR:    w_sReady = 1'b1;
         ST_REPLAY: w_sReady = 1'b0;
         ST_PASS:   w_sReady = w_outRdy;
         ST_DROP:   w_sReady = 1'b1;
         default:   w_sReady = 1'b1;
      endcase
   end

   // Compare the destination against every enabled unicast entry in parallel.
   always_comb begin
      w_uniHit = 1'b0;
      for (int i = 0; i < NumMacEntries; i++) begin
         if (cfg_mac_en_i[i] && (cfg_mac_addr_i[48*i +: 48] == w_dest)) begin
            w_uniHit = 1'b1;
         end
      end
   end

   // Accept on promiscuous, broadcast, group (I/G bit) or a unicast entry hit.
   always_comb begin
      w_accept = cfg_promiscuous_i
              || (cfg_accept_bcast_i && (w_dest == {48{1'b1}}))
              || (cfg_accept_group_i && w_dest[40])
              || w_uniHit;
   end

   // Statistic events all happen on a header-phase input handshake.
   always_comb begin
      w_decide    = (r_state == ST_HDR) && w_inHs && (r_hdrIdx == 3'd5);
      w_acceptInc = w_decide && w_accept;
      w_dropInc   = w_decide && !w_accept;
      w_runtInc   = (r_state == ST_HDR) && w_inHs && s_axis_tlast_i && (r_hdrIdx != 3'd5);
   end

   // Main frame FSM together with the header buffer and the output register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_HDR;
         r_hdrIdx  <= 3'd0;
         r_rdIdx   <= 3'd0;
         r_hdrLast <= 1'b0;
         r_hdrUser <= 1'b0;
         r_eof     <= 1'b0;
         r_mData   <= 8'd0;
         r_mValid  <= 1'b0;
         r_mLast   <= 1'b0;
         r_mUser   <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            r_hdrBuf[i] <= 8'd0;
         end
      end else begin
         if (m_axis_tready_i) begin
            r_mValid <= 1'b0;
         end
         case (r_state)
            ST_HDR: begin
               if (w_inHs) begin
                  r_hdrBuf[r_hdrIdx] <= s_axis_tdata_i;
                  if (r_hdrIdx == 3'd5) begin
                     r_hdrLast <= s_axis_tlast_i;
                     r_hdrUser <= s_axis_tuser_i;
                     r_eof     <= s_axis_tlast_i;
                     r_hdrIdx  <= 3'd0;
                     r_rdIdx   <= 3'd0;
                     if (w_accept) begin
                        r_state <= ST_REPLAY;
                     end else if (!s_axis_tlast_i) begin
                        r_state <= ST_DROP;
                     end
                  end else if (s_axis_tlast_i) begin
                     r_hdrIdx <= 3'd0;
                  end else begin
                     r_hdrIdx <= r_hdrIdx + 3'd1;
                  end
               end
            end
            ST_REPLAY: begin
               if (w_outRdy) begin
                  r_mValid <= 1'b1;
                  r_mData  <= r_hdrBuf[r_rdIdx];
                  if (r_rdIdx == 3'd5) begin
                     r_mLast <= r_hdrLast;
                     r_mUser <= r_hdrUser;
                     r_rdIdx <= 3'd0;
                     r_state <= r_eof ? ST_HDR : ST_PASS;
                  end else begin
                     r_mLast <= 1'b0;
                     r_mUser <= 1'b0;
                     r_rdIdx <= r_rdIdx + 3'd1;
                  end
               end
            end
            ST_PASS: begin
               if (w_inHs) begin
                  r_mValid <= 1'b1;
                  r_mData  <= s_axis_tdata_i;
                  r_mLast  <= s_axis_tlast_i;
                  r_mUser  <= s_axis_tuser_i;
                  if (s_axis_tlast_i) begin
                     r_state <= ST_HDR;
                  end
               end
            end
            ST_DROP: begin
               if (w_inHs && s_axis_tlast_i) begin
                  r_state <= ST_HDR;
               end
            end
            default: r_state <= ST_HDR;
         endcase
      end
   end

   // Saturating statistics; a clear wins over an increment in the same cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_acceptCnt <= '0;
         r_dropCnt   <= '0;
         r_runtCnt   <= '0;
      end else if (cnt_clear_i) begin
         r_acceptCnt <= '0;
         r_dropCnt   <= '0;
         r_runtCnt   <= '0;
      end else begin
         if (w_acceptInc && (r_acceptCnt != {CntWidth{1'b1}})) begin
            r_acceptCnt <= r_acceptCnt + 1'b1;
         end
         if (w_dropInc && (r_dropCnt != {CntWidth{1'b1}})) begin
            r_dropCnt <= r_dropCnt + 1'b1;
         end
         if (w_runtInc && (r_runtCnt != {CntWidth{1'b1}})) begin
            r_runtCnt <= r_runtCnt + 1'b1;
         end
      end
   end

   assign s_axis_tready_o = w_sReady;
   assign m_axis_tdata_o  = r_mData;
   assign m_axis_tvalid_o = r_mValid;
   assign m_axis_tlast_o  = r_mLast;
   assign m_axis_tuser_o  = r_mUser;
   assign accept_cnt_o    = r_acceptCnt;
   assign drop_cnt_o      = r_dropCnt;
   assign runt_cnt_o      = r_runtCnt;

endmodule

// File: tb/tb_eth_rx_addr_filter.sv
// Testbench for eth_rx_addr_filter: directed frames, scoreboard of expected
// output beats, and a second instance with 2-bit counters for saturation.
module tb_eth_rx_addr_filter;

   localparam int NumMacEntries = 4;
   localparam int CntWidth      = 16;

   logic clk = 1'b0;
   logic rst;

   logic [7:0] s_data;
   logic       s_valid, s_last, s_user, s_ready;
   logic [7:0] m_data;
   logic       m_valid, m_last, m_user, m_ready;

   logic [48*NumMacEntries-1:0] cfg_addr;
   logic [NumMacEntries-1:0]    cfg_en;
   logic                        cfg_promisc, cfg_bcast, cfg_group;
   logic                        cnt_clear;
   logic [CntWidth-1:0]         acceptCnt, dropCnt, runtCnt;

   logic       s_ready2, m_valid2, m_last2, m_user2;
   logic [7:0] m_data2;
   logic [1:0] acceptCnt2, dropCnt2, runtCnt2;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [9:0]  sbQ [$];
   logic [47:0] destAddr;
   bit          randReady = 1'b0;
   int          stallCount;
   int          expAccept = 0, expDrop = 0, expRunt = 0;

   localparam logic [47:0] Entry0 = 48'h02_00_00_00_00_01;
   localparam logic [47:0] Entry1 = 48'h02_00_00_00_00_99;
   localparam logic [47:0] Entry2 = 48'h0a_0b_0c_0d_0e_0f;
   localparam logic [47:0] Entry3 = 48'h02_11_22_33_44_55;

   always #4 clk = ~clk;

   eth_rx_addr_filter #(.NumMacEntries(NumMacEntries), .CntWidth(CntWidth)) dut (
      .clk_i(clk), .rst_i(rst),
      .s_axis_tdata_i(s_data), .s_axis_tvalid_i(s_valid), .s_axis_tlast_i(s_last),
      .s_axis_tuser_i(s_user), .s_axis_tready_o(s_ready),
      .m_axis_tdata_o(m_data), .m_axis_tvalid_o(m_valid), .m_axis_tlast_o(m_last),
      .m_axis_tuser_o(m_user), .m_axis_tready_i(m_ready),
      .cfg_mac_addr_i(cfg_addr), .cfg_mac_en_i(cfg_en),
      .cfg_promiscuous_i(cfg_promisc), .cfg_accept_bcast_i(cfg_bcast),
      .cfg_accept_group_i(cfg_group), .cnt_clear_i(cnt_clear),
      .accept_cnt_o(acceptCnt), .drop_cnt_o(dropCnt), .runt_cnt_o(runtCnt)
   );

   eth_rx_addr_filter #(.NumMacEntries(NumMacEntries), .CntWidth(2)) dut2 (
      .clk_i(clk), .rst_i(rst),
      .s_axis_tdata_i(s_data), .s_axis_tvalid_i(s_valid), .s_axis_tlast_i(s_last),
      .s_axis_tuser_i(s_user), .s_axis_tready_o(s_ready2),
      .m_axis_tdata_o(m_data2), .m_axis_tvalid_o(m_valid2), .m_axis_tlast_o(m_last2),
      .m_axis_tuser_o(m_user2), .m_axis_tready_i(m_ready),
      .cfg_mac_addr_i(cfg_addr), .cfg_mac_en_i(cfg_en),
      .cfg_promiscuous_i(cfg_promisc), .cfg_accept_bcast_i(cfg_bcast),
      .cfg_accept_group_i(cfg_group), .cnt_clear_i(cnt_clear),
      .accept_cnt_o(acceptCnt2), .drop_cnt_o(dropCnt2), .runt_cnt_o(runtCnt2)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic reportTimeout(input string name);
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: timed out", name);
   endtask

   task automatic checkCounters(input string name);
      checkOutput({name, " accept_cnt"}, 64'(acceptCnt), 64'(expAccept));
      checkOutput({name, " drop_cnt"},   64'(dropCnt),   64'(expDrop));
      checkOutput({name, " runt_cnt"},   64'(runtCnt),   64'(expRunt));
   endtask

   // Drive one frame; header bytes come from destAddr, the payload is a fixed pattern.
   task automatic applyStimulus(input int len, input bit userLast, input bit expAcc,
                                input bit clrAt5);
      logic [7:0] b;
      bit         hs;
      int         waitCycles;
      stallCount = 0;
      for (int i = 0; i < len; i++) begin
         if (i < 6) b = destAddr[47-8*i -: 8];
         else       b = 8'(i * 7 + len);
         s_valid   = 1'b1;
         s_data    = b;
         s_last    = (i == len - 1);
         s_user    = s_last && userLast;
         cnt_clear = clrAt5 && (i == 5);
         if (expAcc) sbQ.push_back({b, s_last, s_user});
         hs         = 1'b0;
         waitCycles = 0;
         while (!hs) begin
            @(negedge clk);
            hs = s_ready;
            if (!hs) stallCount++;
            @(posedge clk);
            #1;
            waitCycles++;
            if (!hs && waitCycles > 200) begin
               reportTimeout("input handshake");
               s_valid = 1'b0;
               cnt_clear = 1'b0;
               return;
            end
         end
      end
      s_valid   = 1'b0;
      s_last    = 1'b0;
      s_user    = 1'b0;
      cnt_clear = 1'b0;
      if (len >= 6) begin
         if (expAcc) expAccept++;
         else        expDrop++;
      end else begin
         expRunt++;
      end
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      while ((sbQ.size() != 0 || m_valid) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (n >= 3000) reportTimeout({name, " drain"});
   endtask

   // Downstream ready: held high, or a fair coin each cycle when randReady is set.
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pop and compare on every output handshake, and check stall hold.
   initial begin
      logic [10:0] held;
      logic [9:0]  expBeat;
      bit          stalled;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled) checkOutput("stall hold", 64'({m_valid, m_data, m_last, m_user}),
                                     64'(held));
            if (m_valid && m_ready) begin
               if (sbQ.size() == 0) begin
                  testsRun++;
                  testsFailed++;
                  $display("[TB] FAIL unexpected beat: got data 0x%0h last %0b user %0b, expected none",
                           m_data, m_last, m_user);
               end else begin
                  expBeat = sbQ.pop_front();
                  checkOutput("output beat", 64'({m_data, m_last, m_user}), 64'(expBeat));
               end
            end
            stalled = m_valid && !m_ready;
            held    = {m_valid, m_data, m_last, m_user};
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      s_valid     = 1'b0;
      s_data      = 8'd0;
      s_last      = 1'b0;
      s_user      = 1'b0;
      cnt_clear   = 1'b0;
      cfg_addr    = {Entry3, Entry2, Entry1, Entry0};
      cfg_en      = 4'b0101;
      cfg_promisc = 1'b0;
      cfg_bcast   = 1'b0;
      cfg_group   = 1'b0;
      destAddr    = Entry0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      checkOutput("reset m_tvalid", 64'(m_valid), 64'd0);
      checkOutput("reset m_tdata", 64'(m_data), 64'd0);
      checkOutput("reset m_tlast/tuser", 64'({m_last, m_user}), 64'd0);
      checkOutput("reset s_tready", 64'(s_ready), 64'd1);
      checkCounters("reset");
      @(posedge clk);
      #1;

      $display("[TB] 64-byte frame to entry 0");
      destAddr = Entry0;
      applyStimulus(64, 1'b0, 1'b1, 1'b0);
      waitDrain("entry0 frame");
      checkOutput("entry0 accept_cnt", 64'(acceptCnt), 64'd1);

      $display("[TB] 60-byte frame to disabled entry, all modes off");
      destAddr = Entry1;
      applyStimulus(60, 1'b0, 1'b0, 1'b0);
      checkOutput("drop s_tready stalls", 64'(stallCount), 64'd0);
      waitDrain("drop frame");
      checkOutput("drop drop_cnt", 64'(dropCnt), 64'd1);

      $display("[TB] broadcast frame then runt");
      cfg_bcast = 1'b1;
      destAddr  = 48'hff_ff_ff_ff_ff_ff;
      applyStimulus(20, 1'b0, 1'b1, 1'b0);
      destAddr  = Entry0;
      applyStimulus(4, 1'b0, 1'b0, 1'b0);
      waitDrain("bcast+runt");
      checkOutput("runt runt_cnt", 64'(runtCnt), 64'd1);
      checkCounters("bcast+runt");
      cfg_bcast = 1'b0;

      $display("[TB] 100-byte frame with random backpressure and tuser");
      randReady = 1'b1;
      destAddr  = Entry0;
      applyStimulus(100, 1'b1, 1'b1, 1'b0);
      waitDrain("backpressure frame");
      randReady = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] 6-byte frame, entry 2, group and promiscuous");
      destAddr = Entry0;
      applyStimulus(6, 1'b0, 1'b1, 1'b0);
      waitDrain("6-byte frame");
      destAddr = Entry2;
      applyStimulus(8, 1'b0, 1'b1, 1'b0);
      cfg_group = 1'b1;
      destAddr  = 48'h01_00_5e_00_00_01;
      applyStimulus(12, 1'b0, 1'b1, 1'b0);
      waitDrain("group accept");
      cfg_group = 1'b0;
      applyStimulus(12, 1'b0, 1'b0, 1'b0);
      cfg_promisc = 1'b1;
      destAddr    = 48'h12_34_56_78_9a_bc;
      applyStimulus(10, 1'b0, 1'b1, 1'b0);
      waitDrain("promiscuous");
      cfg_promisc = 1'b0;
      checkCounters("modes");

      $display("[TB] back-to-back 6-byte drop then 6-byte accept");
      destAddr = Entry3;
      applyStimulus(6, 1'b0, 1'b0, 1'b0);
      destAddr = Entry0;
      applyStimulus(6, 1'b1, 1'b1, 1'b0);
      waitDrain("back-to-back");
      checkCounters("back-to-back");

      $display("[TB] reset in the middle of a header");
      destAddr = Entry0;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1;
         s_data  = destAddr[47-8*i -: 8];
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      checkOutput("mid reset m_tvalid", 64'(m_valid), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      expAccept = 0;
      expDrop   = 0;
      expRunt   = 0;
      applyStimulus(8, 1'b0, 1'b1, 1'b0);
      waitDrain("after reset");
      checkCounters("after reset");

      $display("[TB] five drops saturate the 2-bit counter");
      destAddr = Entry1;
      for (int f = 0; f < 5; f++) begin
         applyStimulus(7, 1'b0, 1'b0, 1'b0);
         if (f == 1) checkOutput("2-bit drop_cnt at 2", 64'(dropCnt2), 64'd2);
      end
      waitDrain("saturation");
      checkOutput("2-bit drop_cnt saturated", 64'(dropCnt2), 64'd3);
      checkCounters("saturation");

      $display("[TB] counter clear together with a drop");
      applyStimulus(10, 1'b0, 1'b0, 1'b1);
      expAccept = 0;
      expDrop   = 0;
      expRunt   = 0;
      waitDrain("clear");
      checkOutput("clear 2-bit drop_cnt", 64'(dropCnt2), 64'd0);
      checkCounters("clear");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
